ex_cdb_stage: RTL and testbench

EX_CDB_STAGE -- requirements
Module: ex_cdb_stage

---
 rtl/ex_cdb_stage_pkg.sv | 70 +++++++
 rtl/ex_cdb_stage_fu_lane.sv | 93 +++++++++
 rtl/ex_cdb_stage.sv | 103 ++++++++++
 tb/tb_ex_cdb_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_cdb_stage_pkg.sv
// Shared types and constants for the execute / common-data-bus stage.
//   WAYS, XLEN, PRF      : machine-wide widths (lane count, datapath, PRF size)
//   MUL_LAT_DEFAULT      : default multiplier latency in cycles
//   alu_func_e           : ALU operation select
//   lane_state_e         : per-lane FSM state (idle / multiply busy / result held)
//   ID_EX_PACKET         : issued op as delivered by the reservation station
//   alu_compute()        : single-cycle ALU function
package ex_cdb_stage_pkg;

  localparam int unsigned WAYS            = 3;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned PRF             = 64;
  localparam int unsigned PRF_IDX_W       = $clog2(PRF);
  localparam int unsigned SHAMT_W         = $clog2(XLEN);
  localparam int unsigned MUL_LAT_DEFAULT = 4;
  // Wide enough for MUL_LAT-2 with MUL_LAT up to 15.
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu
  } alu_func_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StHold
  } lane_state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic [PRF_IDX_W-1:0] dest_prf_idx;
    alu_func_e            alu_func;
    logic                 is_mul;
  } ID_EX_PACKET;

  function automatic logic [XLEN-1:0] alu_compute(input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b,
                                                  input alu_func_e       f);
    logic [XLEN-1:0]    res;
    logic [SHAMT_W-1:0] sh;
    sh  = b[SHAMT_W-1:0];
    res = '0;
    unique case (f)
      AluAdd:  res = a + b;
      AluSub:  res = a - b;
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluXor:  res = a ^ b;
      AluSll:  res = a << sh;
      AluSrl:  res = a >> sh;
      AluSra:  res = XLEN'($signed(a) >>> sh);
      AluSlt:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      AluSltu: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_cdb_stage_fu_lane.sv
// One execute lane: accepts an issued op, computes it (ALU in one cycle, multiply over
// MUL_LAT cycles) and holds the result until the CDB arbiter grants it.
//   clock, reset  : system clock, synchronous active-high reset
//   packet_i      : issued op for this lane
//   grant_i       : CDB grant for this lane (only meaningful in HOLD)
//   req_o         : lane holds a result and requests the CDB
//   occupied_o    : lane cannot accept an op this cycle
//   drop_o        : a valid op is being presented to an occupied lane
//   result_o      : held result
//   dest_o        : held destination PRF index
module fu_lane
  import ex_cdb_stage_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  ID_EX_PACKET          packet_i,
  input  logic                 grant_i,
  output logic                 req_o,
  output logic                 occupied_o,
  output logic                 drop_o,
  output logic [XLEN-1:0]      result_o,
  output logic [PRF_IDX_W-1:0] dest_o
);

  lane_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [PRF_IDX_W-1:0] dest_q, dest_d;

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_low;

  // A granted HOLD lane frees up in the same cycle, so a new op can land behind it.
  assign occupied_o = (state_q == StBusy) | ((state_q == StHold) & ~grant_i);
  assign req_o      = (state_q == StHold);
  assign accept     = packet_i.valid & ~occupied_o;
  assign drop_o     = packet_i.valid & occupied_o;
  assign result_o   = result_q;
  assign dest_o     = dest_q;

  assign alu_res = alu_compute(packet_i.rs1_value, packet_i.rs2_value, packet_i.alu_func);
  assign mul_low = packet_i.rs1_value * packet_i.rs2_value;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dest_d   = dest_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      StHold: begin
        if (grant_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      dest_d = packet_i.dest_prf_idx;
      if (packet_i.is_mul) begin
        // Counter runs MUL_LAT-2 .. 0 in BUSY, then one HOLD cycle: MUL_LAT cycles total.
        state_d  = StBusy;
        cnt_d    = CNT_W'(MUL_LAT - 2);
        result_d = mul_low;
      end else begin
        state_d  = StHold;
        result_d = alu_res;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

endmodule

// File: rtl/ex_cdb_stage.sv
// Execute stage with N_FU lanes sharing CDB_W common-data-bus broadcast slots.
// Holding lanes are granted round-robin from rr_ptr and packed into slots 0, 1, ...
//   clock, reset  : system clock, synchronous active-high reset
//   issue_packet  : per-lane issued op from the reservation station
//   ALU_occupied  : per-lane "cannot accept" back to the reservation station
//   CDB_Data      : broadcast results per slot
//   CDB_PRF_idx   : destination PRF index per slot
//   CDB_valid     : slot valid, thermometer from bit 0
//   issue_err     : one-cycle pulse, a valid op hit an occupied lane last cycle
module ex_cdb_stage
  import ex_cdb_stage_pkg::*;
#(
  parameter int unsigned N_FU    = WAYS,
  parameter int unsigned CDB_W   = WAYS,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  ID_EX_PACKET          issue_packet [N_FU],
  output logic [N_FU-1:0]      ALU_occupied,
  output logic [XLEN-1:0]      CDB_Data     [CDB_W],
  output logic [PRF_IDX_W-1:0] CDB_PRF_idx  [CDB_W],
  output logic [CDB_W-1:0]     CDB_valid,
  output logic                 issue_err
);

  localparam int unsigned PTR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int unsigned SLOT_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;
  localparam int unsigned SCNT_W = $clog2(CDB_W + 1);

  logic [N_FU-1:0]      req;
  logic [N_FU-1:0]      grant;
  logic [N_FU-1:0]      drop;
  logic [XLEN-1:0]      lane_result [N_FU];
  logic [PRF_IDX_W-1:0] lane_dest   [N_FU];

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             issue_err_q;

  for (genvar i = 0; i < N_FU; i++) begin : g_lane
    fu_lane #(
      .MUL_LAT(MUL_LAT)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .packet_i  (issue_packet[i]),
      .grant_i   (grant[i]),
      .req_o     (req[i]),
      .occupied_o(ALU_occupied[i]),
      .drop_o    (drop[i]),
      .result_o  (lane_result[i]),
      .dest_o    (lane_dest[i])
    );
  end

  // Arbiter and slot packing; depends only on lane registers and rr_ptr.
  logic [PTR_W:0]      sum;
  logic [PTR_W:0]      nxt;
  logic [PTR_W-1:0]    idx;
  logic [SCNT_W-1:0]   nslot;

  always_comb begin
    grant     = '0;
    rr_ptr_d  = rr_ptr_q;
    CDB_valid = '0;
    for (int s = 0; s < int'(CDB_W); s++) begin
      CDB_Data[s]    = '0;
      CDB_PRF_idx[s] = '0;
    end
    sum   = '0;
    nxt   = '0;
    idx   = '0;
    nslot = '0;
    for (int k = 0; k < int'(N_FU); k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N_FU)) sum = sum - (PTR_W + 1)'(N_FU);
      idx = sum[PTR_W-1:0];
      if (req[idx] && (nslot < SCNT_W'(CDB_W))) begin
        grant[idx]                        = 1'b1;
        CDB_valid[nslot[SLOT_W-1:0]]      = 1'b1;
        CDB_Data[nslot[SLOT_W-1:0]]       = lane_result[idx];
        CDB_PRF_idx[nslot[SLOT_W-1:0]]    = lane_dest[idx];
        nslot                             = nslot + SCNT_W'(1);
        nxt = sum + (PTR_W + 1)'(1);
        if (nxt == (PTR_W + 1)'(N_FU)) nxt = '0;
        rr_ptr_d = nxt[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      issue_err_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_err_q <= |drop;
    end
  end

  assign issue_err = issue_err_q;

endmodule

// File: tb/tb_ex_cdb_stage.sv
// Self-checking bench for ex_cdb_stage with N_FU=3, CDB_W=2, MUL_LAT=4.
// Expected broadcasts are queued when ops are issued and popped as the CDB shows them.
module tb_ex_cdb_stage;
  import ex_cdb_stage_pkg::*;

  logic                 clock;
  logic                 reset;
  ID_EX_PACKET          pkt [3];
  logic [2:0]           alu_occ;
  logic [XLEN-1:0]      cdb_data [2];
  logic [PRF_IDX_W-1:0] cdb_idx  [2];
  logic [1:0]           cdb_valid;
  logic                 issue_err;

  ex_cdb_stage #(
    .N_FU   (3),
    .CDB_W  (2),
    .MUL_LAT(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_packet(pkt),
    .ALU_occupied(alu_occ),
    .CDB_Data    (cdb_data),
    .CDB_PRF_idx (cdb_idx),
    .CDB_valid   (cdb_valid),
    .issue_err   (issue_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [XLEN-1:0]      data;
    logic [PRF_IDX_W-1:0] idx;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    int                   lane;
    alu_func_e            func;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic                 is_mul;
    logic [PRF_IDX_W-1:0] dest;
    logic [XLEN-1:0]      exp;
    int                   lat;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic issue(input int lane, input alu_func_e f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [PRF_IDX_W-1:0] dest,
                       input logic mul);
    pkt[lane] = '{valid: 1'b1, rs1_value: a, rs2_value: b, dest_prf_idx: dest,
                  alu_func: f, is_mul: mul};
  endtask

  task automatic clear_all();
    for (int l = 0; l < 3; l++) pkt[l] = '0;
  endtask

  task automatic push(input logic [XLEN-1:0] d, input logic [PRF_IDX_W-1:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    sbq.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every valid slot must match the next queued result, in slot order.
  always @(negedge clock) begin
    if (!reset) begin
      check("cdb_valid_thermometer", {63'd0, (cdb_valid == 2'b10)}, 64'd0);
      for (int s = 0; s < 2; s++) begin
        if (cdb_valid[s]) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cdb_unexpected: slot %0d data=%0h idx=%0d with nothing expected @%0t",
                     s, cdb_data[s], cdb_idx[s], $time);
          end else begin
            mon_e = sbq.pop_front();
            check("cdb_data", cdb_data[s], mon_e.data);
            check("cdb_idx", cdb_idx[s], mon_e.idx);
          end
        end else begin
          check("cdb_unused_data", cdb_data[s], 0);
          check("cdb_unused_idx", cdb_idx[s], 0);
        end
      end
    end
  end

  int lat;
  bit got;

  initial begin
    vecs[0]  = '{0, AluAdd,  32'd5,          32'd7,          1'b0, 6'd12, 32'd12,         1};
    vecs[1]  = '{1, AluSub,  32'd10,         32'd3,          1'b0, 6'd13, 32'd7,          1};
    vecs[2]  = '{2, AluAnd,  32'h0000_00f0,  32'h0000_003c,  1'b0, 6'd14, 32'h0000_0030,  1};
    vecs[3]  = '{0, AluOr,   32'h0000_00f0,  32'h0000_000f,  1'b0, 6'd15, 32'h0000_00ff,  1};
    vecs[4]  = '{1, AluXor,  32'h0000_00ff,  32'h0000_000f,  1'b0, 6'd16, 32'h0000_00f0,  1};
    vecs[5]  = '{2, AluSll,  32'd1,          32'd4,          1'b0, 6'd17, 32'd16,         1};
    vecs[6]  = '{0, AluSrl,  32'h8000_0000,  32'd31,         1'b0, 6'd18, 32'd1,          1};
    vecs[7]  = '{1, AluSra,  32'h8000_0000,  32'd31,         1'b0, 6'd19, 32'hffff_ffff,  1};
    vecs[8]  = '{2, AluSlt,  32'hffff_ffff,  32'd1,          1'b0, 6'd20, 32'd1,          1};
    vecs[9]  = '{0, AluSltu, 32'hffff_ffff,  32'd1,          1'b0, 6'd21, 32'd0,          1};
    vecs[10] = '{1, AluAdd,  32'd6,          32'd7,          1'b1, 6'd9,  32'd42,         4};
    vecs[11] = '{2, AluAdd,  32'h0001_0001,  32'h0001_0001,  1'b1, 6'd22, 32'h0002_0001,  4};
    vecs[12] = '{0, AluSub,  32'd0,          32'd1,          1'b0, 6'd63, 32'hffff_ffff,  1};

    clear_all();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("reset_cdb_valid", cdb_valid, 0);
    check("reset_occupied", alu_occ, 0);
    check("reset_issue_err", issue_err, 0);
    check("reset_cdb_data0", cdb_data[0], 0);
    step();

    // One op at a time: latency, occupancy while multiplying, and lane free afterwards.
    for (int v = 0; v < 13; v++) begin
      issue(vecs[v].lane, vecs[v].func, vecs[v].a, vecs[v].b, vecs[v].dest, vecs[v].is_mul);
      push(vecs[v].exp, vecs[v].dest);
      step();
      clear_all();
      lat = 0;
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
        @(negedge clock);
        if (cdb_valid[0]) begin
          got = 1'b1;
          lat = c;
          check("bcast_slots", cdb_valid, 2'b01);
          check("bcast_lane_free", alu_occ[vecs[v].lane], 0);
        end else begin
          if (vecs[v].is_mul) check("mul_occupied", alu_occ[vecs[v].lane], 1);
          step();
        end
      end
      check("latency", lat, vecs[v].lat);
      step();
      @(negedge clock);
      check("after_bcast_idle_valid", cdb_valid, 0);
      check("after_bcast_idle_occ", alu_occ, 0);
      step();
    end

    // All three lanes at once from rr_ptr=0: lanes 0,1 then lane2; pointer wraps to 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(0, AluAdd, 32'd1, 32'd1, 6'd40, 1'b0);
    issue(1, AluAdd, 32'd2, 32'd2, 6'd41, 1'b0);
    issue(2, AluAdd, 32'd3, 32'd3, 6'd42, 1'b0);
    push(32'd2, 6'd40);
    push(32'd4, 6'd41);
    push(32'd6, 6'd42);
    step();
    clear_all();
    @(negedge clock);
    check("rr3_t1_valid", cdb_valid, 2'b11);
    check("rr3_t1_occ", alu_occ, 3'b100);
    step();
    @(negedge clock);
    check("rr3_t2_valid", cdb_valid, 2'b01);
    check("rr3_t2_occ", alu_occ, 3'b000);
    step();
    // rr_ptr back at 0: lanes 0,1 first; refill them while lane2 waits, then 2,0 then 1.
    issue(0, AluAdd, 32'd4, 32'd4, 6'd43, 1'b0);
    issue(1, AluAdd, 32'd5, 32'd5, 6'd44, 1'b0);
    issue(2, AluAdd, 32'd6, 32'd6, 6'd45, 1'b0);
    push(32'd8, 6'd43);
    push(32'd10, 6'd44);
    push(32'd12, 6'd45);
    push(32'd14, 6'd46);
    push(32'd16, 6'd47);
    step();
    clear_all();
    issue(0, AluAdd, 32'd7, 32'd7, 6'd46, 1'b0);
    issue(1, AluAdd, 32'd8, 32'd8, 6'd47, 1'b0);
    @(negedge clock);
    check("rr_b_t1_valid", cdb_valid, 2'b11);
    check("rr_b_t1_occ", alu_occ, 3'b100);
    step();
    clear_all();
    @(negedge clock);
    check("rr_b_t2_valid", cdb_valid, 2'b11);
    check("rr_b_t2_occ", alu_occ, 3'b010);
    check("rr_b_no_err", issue_err, 0);
    step();
    @(negedge clock);
    check("rr_b_t3_valid", cdb_valid, 2'b01);
    step();
    @(negedge clock);
    check("rr_b_t4_valid", cdb_valid, 2'b00);
    step();

    // Back-to-back ADDs on lane0: one broadcast per cycle, never an issue error.
    for (int i = 0; i < 8; i++) begin
      issue(0, AluAdd, 32'(i), 32'd100, 6'(i + 1), 1'b0);
      push(32'(i + 100), 6'(i + 1));
      @(negedge clock);
      if (i > 0) check("b2b_valid", cdb_valid[0], 1);
      check("b2b_no_err", issue_err, 0);
      step();
    end
    clear_all();
    @(negedge clock);
    check("b2b_last_valid", cdb_valid[0], 1);
    check("b2b_last_no_err", issue_err, 0);
    step();
    @(negedge clock);
    check("b2b_drained", cdb_valid, 0);
    step();

    // Op to a busy multiplier lane is dropped and flagged for exactly one cycle.
    issue(1, AluAdd, 32'd6, 32'd7, 6'd9, 1'b1);
    push(32'd42, 6'd9);
    step();
    clear_all();
    issue(1, AluAdd, 32'd1, 32'd1, 6'd5, 1'b0);
    @(negedge clock);
    check("drop_err_not_yet", issue_err, 0);
    step();
    clear_all();
    @(negedge clock);
    check("drop_err_pulse", issue_err, 1);
    check("drop_lane_busy", alu_occ[1], 1);
    step();
    @(negedge clock);
    check("drop_err_cleared", issue_err, 0);
    step();
    @(negedge clock);
    check("drop_mul_bcast", cdb_valid, 2'b01);
    step();
    @(negedge clock);
    check("drop_no_extra", cdb_valid, 0);
    step();

    // Reset while lane1 holds a product: nothing broadcast, op presented during reset ignored.
    issue(1, AluAdd, 32'd3, 32'd3, 6'd30, 1'b1);
    step();
    clear_all();
    step();
    step();
    step();
    reset = 1'b1;
    issue(0, AluAdd, 32'd9, 32'd9, 6'd31, 1'b0);
    step();
    reset = 1'b0;
    clear_all();
    @(negedge clock);
    check("rst_mid_valid", cdb_valid, 0);
    check("rst_mid_occ", alu_occ, 0);
    check("rst_mid_data0", cdb_data[0], 0);
    check("rst_mid_idx0", cdb_idx[0], 0);
    check("rst_mid_err", issue_err, 0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clock);
    check("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
